simmem_wrsp_generator: RTL and testbench
========================================

# simmem_wrsp_generator

Write-side responder stub for the simulated memory controller: sits at the far end of the AXI write channels, downstream of the delay calculator and message banks, standing in for the real memory. Accepts write address and write data requests with independent handshakes, data allowed before its address. Emits exactly one write response per address once all of that address's data beats have arrived, in address-acceptance order.

## Interface
- AddrFifoDepth, default 4: write addresses buffered awaiting data; power of two, ≥2.
- MaxPendingBeats, default MaxBurstEffLen*AddrFifoDepth: saturation limit of the unattributed-beat counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- waddr_i  in  simmem_pkg::waddr_t  write address request (id, burst_len used).
- waddr_valid_i  in  1  address valid.
- waddr_ready_o  out  1  address ready.
- wdata_valid_i  in  1  write data beat valid; content ignored.
- wdata_ready_o  out  1  write data ready.
- wrsp_o  out  simmem_pkg::wrsp_t  write response: id of completed address, rsp = OKAY ('0).
- wrsp_valid_o  out  1  response valid.
- wrsp_ready_i  in  1  response ready.

## Operation
- Address FIFO: push on waddr_valid_i && waddr_ready_o. waddr_ready_o = !full, from registered occupancy; no push into a full FIFO even when a pop happens the same cycle.
- Beat counter beat_cnt_q: unsigned, $clog2(MaxPendingBeats)+1 bits, counts accepted beats not yet attributed to an address. wdata_ready_o = beat_cnt_q < MaxPendingBeats.
- Effective length L = get_effective_burst_len(head.burst_len) (burst_len+1).
- FSM, two states:
  - IDLE: wrsp_valid_o=0. If FIFO non-empty and beat_cnt_q ≥ L of head: pop head, register wrsp_o.id = head.id, rsp = OKAY, go to RSP.
  - RSP: wrsp_valid_o=1; wrsp_o held stable. On wrsp_ready_i: if the next head is also complete (same rule, on _q values), pop it and load it, staying in RSP (back-to-back); else go to IDLE.
- Counter update in one combinational expression: beat_cnt_d = beat_cnt_q + (beat handshake) − (L if pop). Never underflows, since a pop requires beat_cnt_q ≥ L.
- Excess beats beyond a burst stay in the counter for the next address.
- Responses always follow address-acceptance order; no reordering by id.

## Timing
- Reset (asynchronous assert, synchronous-to-clock release):
  - FIFO empty, beat_cnt_q=0, state IDLE.
  - wrsp_valid_o=0, wrsp_o='0, waddr_ready_o=1, wdata_ready_o=1.
- Reset mid-operation discards buffered addresses, counted beats and any pending response without completing its handshake.
- Latency, address present first: the completing beat's handshake at edge t gives wrsp_valid_o high from edge t+1; the response handshake at edge t+k needs wrsp_ready_i high.
- Latency, data complete before address: address handshake at edge t gives wrsp_valid_o from edge t+1.
- Throughput: one response per cycle when heads are complete and wrsp_ready_i is held high.
- Simultaneous events:
  - Beat accept and pop in the same cycle both apply.
  - A push into an empty FIFO is not visible to the FSM until the next cycle.
- Counter at MaxPendingBeats: wdata_ready_o low until a pop.

## Configuration
- SIMMEM_WRSP_GEN_ASSERT_EN defined: SVA checks are compiled in:
  - no push when full;
  - beat_cnt_q never exceeds MaxPendingBeats;
  - wrsp_o stable while wrsp_valid_o && !wrsp_ready_i;
  - wrsp_valid_o never drops without a handshake.
- Undefined: no assertions; cycle behaviour identical.

## Structure
- simmem_pkg supplies waddr_t, wrsp_t, get_effective_burst_len and MaxBurstEffLen.
- Add to simmem_pkg: a WRspOkay constant and the AddrFifoDepth default, WRspGenAddrFifoDepth.
- One sub-module: simmem_addr_fifo, a generic registered FIFO of waddr_t with push/pop/full/empty. FSM and counter stay in the top.

## Test plan
- Address id=3, burst_len=1, then 2 beats on consecutive cycles → wrsp_valid_o high 1 cycle after the 2nd beat, wrsp_o.id=3, rsp=0.
- 4 beats, then address id=5 burst_len=3 → response id=5 1 cycle after the address handshake; beat_cnt_q returns to 0.
- Addresses id=1,2,3 (burst_len=0 each), 3 beats, wrsp_ready_i held low 5 cycles then high → id=1 held stable throughout; then ids 1,2,3 on 3 consecutive cycles.
- Fill FIFO with 4 addresses, no data → waddr_ready_o=0; one beat completing the head plus a response handshake → waddr_ready_o=1 one cycle after the pop.
- Stream beats with no address until MaxPendingBeats → wdata_ready_o=0; a burst_len=0 address plus response handshake → wdata_ready_o=1 again.
- Assert rst_i while wrsp_valid_o=1 and 2 addresses are queued → all outputs at reset values immediately; no response after release.

Source files
------------

// File: rtl/simmem_pkg.sv
// Shared types for the simulated memory controller.
// Holds AXI write address/response types and write-response defaults.
package simmem_pkg;

  localparam int unsigned IdWidth       = 4;
  localparam int unsigned AddrWidth     = 32;
  localparam int unsigned BurstLenWidth = 4;
  localparam int unsigned RspWidth      = 2;

  localparam int unsigned MaxBurstEffLen = 2 ** BurstLenWidth;
  localparam int unsigned WRspGenAddrFifoDepth = 4;

  localparam logic [RspWidth-1:0] WRspOkay = '0;

  typedef struct packed {
    logic [IdWidth-1:0]       id;
    logic [AddrWidth-1:0]     addr;
    logic [BurstLenWidth-1:0] burst_len;
  } waddr_t;

  typedef struct packed {
    logic [IdWidth-1:0]  id;
    logic [RspWidth-1:0] rsp;
  } wrsp_t;

  function automatic logic [BurstLenWidth:0] get_effective_burst_len(
    input logic [BurstLenWidth-1:0] burst_len
  );
    return {1'b0, burst_len} + 1'b1;
  endfunction

endpackage

// File: rtl/simmem_wrsp_generator_if.sv
// Write address, write data and write response channels
// of the simulated memory write responder.
interface simmem_wrsp_generator_if;
  import simmem_pkg::*;

  waddr_t waddr_i;
  logic   waddr_valid_i;
  logic   waddr_ready_o;
  logic   wdata_valid_i;
  logic   wdata_ready_o;
  wrsp_t  wrsp_o;
  logic   wrsp_valid_o;
  logic   wrsp_ready_i;

  modport slave (
    input  waddr_i, waddr_valid_i,
    input  wdata_valid_i, wrsp_ready_i,
    output waddr_ready_o, wdata_ready_o,
    output wrsp_o, wrsp_valid_o
  );

  modport master (
    output waddr_i, waddr_valid_i,
    output wdata_valid_i, wrsp_ready_i,
    input  waddr_ready_o, wdata_ready_o,
    input  wrsp_o, wrsp_valid_o
  );

endinterface

// File: rtl/simmem_wrsp_generator_addr_fifo.sv
// Registered FIFO of write addresses; full/empty come
// from registered occupancy only.
module simmem_addr_fifo
  import simmem_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  waddr_t data_i,
  input  logic   pop_i,
  output waddr_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  waddr_t            r_mem [Depth];
  logic [PtrW-1:0]   r_wptr;
  logic [PtrW-1:0]   r_rptr;
  logic [PtrW:0]     r_cnt;
  logic              w_push;
  logic              w_pop;

  assign full_o  = r_cnt == (PtrW+1)'(Depth);
  assign empty_o = r_cnt == '0;
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign head_o  = r_mem[r_rptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      r_cnt <= r_cnt + (PtrW+1)'(w_push)
                     - (PtrW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/simmem_wrsp_generator.sv
// Write responder stub: one in-order response per address once its beats
// have arrived. SIMMEM_WRSP_GEN_ASSERT_EN compiles in protocol checks.
module simmem_wrsp_generator
  import simmem_pkg::*;
#(
  parameter int unsigned AddrFifoDepth   = WRspGenAddrFifoDepth,
  parameter int unsigned MaxPendingBeats = MaxBurstEffLen * AddrFifoDepth
) (
  input logic clk_i,
  input logic rst_i,
  simmem_wrsp_generator_if.slave bus
);

  localparam int unsigned CntW = $clog2(MaxPendingBeats) + 1;

  typedef enum logic {
    IDLE,
    RSP
  } state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic [CntW-1:0]     r_beat_cnt;
  logic [CntW-1:0]     w_beat_cnt_d;
  wrsp_t               r_wrsp;
  waddr_t              w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_beat;
  logic                w_head_done;
  logic [BurstLenWidth:0] w_len;

  simmem_addr_fifo #(
    .Depth (AddrFifoDepth)
  ) u_addr_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (bus.waddr_i),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign bus.waddr_ready_o = !w_full;
  assign bus.wdata_ready_o = r_beat_cnt < CntW'(MaxPendingBeats);
  assign bus.wrsp_o        = r_wrsp;
  assign bus.wrsp_valid_o  = r_state == RSP;

  assign w_push = bus.waddr_valid_i && !w_full;
  assign w_beat = bus.wdata_valid_i && bus.wdata_ready_o;
  assign w_len  = get_effective_burst_len(w_head.burst_len);
  assign w_head_done = !w_empty && (r_beat_cnt >= CntW'(w_len));

  always_comb begin
    w_state_d = r_state;
    w_pop     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_head_done) begin
          w_pop     = 1'b1;
          w_state_d = RSP;
        end
      end
      RSP: begin
        if (bus.wrsp_ready_i) begin
          // Chain the next complete head without a bubble.
          if (w_head_done) w_pop = 1'b1;
          else             w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  assign w_beat_cnt_d = r_beat_cnt + CntW'(w_beat)
                      - (w_pop ? CntW'(w_len) : '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
      r_wrsp     <= '0;
    end else begin
      r_state    <= w_state_d;
      r_beat_cnt <= w_beat_cnt_d;
      if (w_pop) begin
        r_wrsp.id  <= w_head.id;
        r_wrsp.rsp <= WRspOkay;
      end
    end
  end

`ifdef SIMMEM_WRSP_GEN_ASSERT_EN
  a_no_push_full: assert property (
    @(posedge clk_i) disable iff (rst_i)
    w_push |-> !w_full);

  a_cnt_limit: assert property (
    @(posedge clk_i) disable iff (rst_i)
    r_beat_cnt <= CntW'(MaxPendingBeats));

  a_rsp_stable: assert property (
    @(posedge clk_i) disable iff (rst_i)
    bus.wrsp_valid_o && !bus.wrsp_ready_i |=> $stable(bus.wrsp_o));

  a_valid_held: assert property (
    @(posedge clk_i) disable iff (rst_i)
    bus.wrsp_valid_o && !bus.wrsp_ready_i |=> bus.wrsp_valid_o);
`else
`endif

endmodule

// File: tb/tb_simmem_wrsp_generator.sv
// Directed self-checking bench for simmem_wrsp_generator.
// Each scenario task drives stimulus and checks inline.
module tb_simmem_wrsp_generator;
  import simmem_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  simmem_wrsp_generator_if bus ();

  simmem_wrsp_generator dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.waddr_i       = '0;
    bus.waddr_valid_i = 1'b0;
    bus.wdata_valid_i = 1'b0;
    bus.wrsp_ready_i  = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_addr(input int id, input int bl);
    bus.waddr_i.id        = IdWidth'(id);
    bus.waddr_i.addr      = '0;
    bus.waddr_i.burst_len = BurstLenWidth'(bl);
    bus.waddr_valid_i     = 1'b1;
    tick();
    bus.waddr_valid_i     = 1'b0;
  endtask

  task automatic beats(input int n);
    bus.wdata_valid_i = 1'b1;
    repeat (n) tick();
    bus.wdata_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tests++;
    if (bus.wrsp_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: got %b want 0", bus.wrsp_valid_o);
    end
    tests++;
    if (bus.wrsp_o !== '0) begin
      fails++;
      $display("FAIL reset_wrsp: got %h want 0", bus.wrsp_o);
    end
    tests++;
    if (bus.waddr_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_aready: got %b want 1", bus.waddr_ready_o);
    end
    tests++;
    if (bus.wdata_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_dready: got %b want 1", bus.wdata_ready_o);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_addr_first;
    do_reset();
    push_addr(3, 1);
    beats(2);
    tests++;
    if (bus.wrsp_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL af_early: got %b want 0", bus.wrsp_valid_o);
    end
    tick();
    tests++;
    if (bus.wrsp_valid_o !== 1'b1 || bus.wrsp_o.id !== 4'd3
        || bus.wrsp_o.rsp !== 2'd0) begin
      fails++;
      $display("FAIL af_rsp: got v=%b id=%0d rsp=%0d want v=1 id=3 rsp=0",
               bus.wrsp_valid_o, bus.wrsp_o.id, bus.wrsp_o.rsp);
    end
    bus.wrsp_ready_i = 1'b1;
    tick();
    bus.wrsp_ready_i = 1'b0;
    tests++;
    if (bus.wrsp_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL af_done: got %b want 0", bus.wrsp_valid_o);
    end
  endtask

  task automatic test_data_first;
    do_reset();
    beats(4);
    push_addr(5, 3);
    tests++;
    if (bus.wrsp_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL df_early: got %b want 0", bus.wrsp_valid_o);
    end
    tick();
    tests++;
    if (bus.wrsp_valid_o !== 1'b1 || bus.wrsp_o.id !== 4'd5) begin
      fails++;
      $display("FAIL df_rsp: got v=%b id=%0d want v=1 id=5",
               bus.wrsp_valid_o, bus.wrsp_o.id);
    end
    bus.wrsp_ready_i = 1'b1;
    tick();
    bus.wrsp_ready_i = 1'b0;
    push_addr(6, 0);
    repeat (3) tick();
    tests++;
    if (bus.wrsp_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL df_cnt_zero: got %b want 0", bus.wrsp_valid_o);
    end
    beats(1);
    tick();
    tests++;
    if (bus.wrsp_valid_o !== 1'b1 || bus.wrsp_o.id !== 4'd6) begin
      fails++;
      $display("FAIL df_next: got v=%b id=%0d want v=1 id=6",
               bus.wrsp_valid_o, bus.wrsp_o.id);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    push_addr(1, 0);
    push_addr(2, 0);
    push_addr(3, 0);
    beats(3);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (bus.wrsp_valid_o !== 1'b1 || bus.wrsp_o.id !== 4'd1) begin
        fails++;
        $display("FAIL bb_hold%0d: got v=%b id=%0d want v=1 id=1",
                 i, bus.wrsp_valid_o, bus.wrsp_o.id);
      end
      tick();
    end
    bus.wrsp_ready_i = 1'b1;
    tests++;
    if (bus.wrsp_valid_o !== 1'b1 || bus.wrsp_o.id !== 4'd1) begin
      fails++;
      $display("FAIL bb_id1: got v=%b id=%0d want v=1 id=1",
               bus.wrsp_valid_o, bus.wrsp_o.id);
    end
    tick();
    tests++;
    if (bus.wrsp_valid_o !== 1'b1 || bus.wrsp_o.id !== 4'd2) begin
      fails++;
      $display("FAIL bb_id2: got v=%b id=%0d want v=1 id=2",
               bus.wrsp_valid_o, bus.wrsp_o.id);
    end
    tick();
    tests++;
    if (bus.wrsp_valid_o !== 1'b1 || bus.wrsp_o.id !== 4'd3) begin
      fails++;
      $display("FAIL bb_id3: got v=%b id=%0d want v=1 id=3",
               bus.wrsp_valid_o, bus.wrsp_o.id);
    end
    tick();
    bus.wrsp_ready_i = 1'b0;
    tests++;
    if (bus.wrsp_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL bb_end: got %b want 0", bus.wrsp_valid_o);
    end
  endtask

  task automatic test_fifo_full;
    do_reset();
    for (int i = 0; i < 4; i++) push_addr(8 + i, 0);
    tests++;
    if (bus.waddr_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL ff_full: got %b want 0", bus.waddr_ready_o);
    end
    beats(1);
    tests++;
    if (bus.waddr_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL ff_prepop: got %b want 0", bus.waddr_ready_o);
    end
    tick();
    tests++;
    if (bus.waddr_ready_o !== 1'b1 || bus.wrsp_o.id !== 4'd8) begin
      fails++;
      $display("FAIL ff_pop: got rdy=%b id=%0d want rdy=1 id=8",
               bus.waddr_ready_o, bus.wrsp_o.id);
    end
    bus.wrsp_ready_i = 1'b1;
    tick();
    bus.wrsp_ready_i = 1'b0;
    tests++;
    if (bus.waddr_ready_o !== 1'b1 || bus.wrsp_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL ff_after: got rdy=%b v=%b want rdy=1 v=0",
               bus.waddr_ready_o, bus.wrsp_valid_o);
    end
  endtask

  task automatic test_saturation;
    do_reset();
    beats(63);
    tests++;
    if (bus.wdata_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL sat_63: got %b want 1", bus.wdata_ready_o);
    end
    beats(1);
    tests++;
    if (bus.wdata_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL sat_64: got %b want 0", bus.wdata_ready_o);
    end
    beats(2);
    tests++;
    if (bus.wdata_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL sat_hold: got %b want 0", bus.wdata_ready_o);
    end
    push_addr(2, 0);
    tick();
    tests++;
    if (bus.wrsp_valid_o !== 1'b1 || bus.wrsp_o.id !== 4'd2) begin
      fails++;
      $display("FAIL sat_rsp: got v=%b id=%0d want v=1 id=2",
               bus.wrsp_valid_o, bus.wrsp_o.id);
    end
    bus.wrsp_ready_i = 1'b1;
    tick();
    bus.wrsp_ready_i = 1'b0;
    tests++;
    if (bus.wdata_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL sat_release: got %b want 1", bus.wdata_ready_o);
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    do_reset();
    push_addr(1, 0);
    push_addr(2, 0);
    push_addr(3, 0);
    beats(1);
    tick();
    tests++;
    if (bus.wrsp_valid_o !== 1'b1 || bus.wrsp_o.id !== 4'd1) begin
      fails++;
      $display("FAIL rm_pre: got v=%b id=%0d want v=1 id=1",
               bus.wrsp_valid_o, bus.wrsp_o.id);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (bus.wrsp_valid_o !== 1'b0 || bus.wrsp_o !== '0
        || bus.waddr_ready_o !== 1'b1 || bus.wdata_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL rm_async: got v=%b rsp=%h ar=%b dr=%b want 0 0 1 1",
               bus.wrsp_valid_o, bus.wrsp_o,
               bus.waddr_ready_o, bus.wdata_ready_o);
    end
    tick();
    rst = 1'b0;
    bus.wrsp_ready_i = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (bus.wrsp_valid_o !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL rm_norsp: got valid=1 want 0 after release");
    end
    push_addr(7, 0);
    repeat (3) tick();
    tests++;
    if (bus.wrsp_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL rm_cnt_clr: got %b want 0", bus.wrsp_valid_o);
    end
    bus.wrsp_ready_i = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_addr_first();
    test_data_first();
    test_back_to_back();
    test_fifo_full();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
